// File: rtl/scan_alu_pkg.sv
// Shared constants for the scan-chain ALU: widths and opcodes.
// Imported by alu4_comb and scan_chain_alu.
package scan_alu_pkg;

  localparam int DATA_W    = 4;
  localparam int CHAIN_LEN = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu4_comb.sv
// Purely combinational 4-bit ALU; all results truncate to 4 bits.
// Ports: a, b (operands), opcode (op select) -> result, zero (result == 0).
module alu4_comb
  import scan_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    unique case (opcode)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: result = {a[DATA_W-2:0], 1'b0};
      OP_SHR: result = {1'b0, a[DATA_W-1:1]};
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/scan_chain_alu.sv
// 4-bit ALU whose operand registers double as an 8-bit scan chain {a_q, b_q}.
// Ports: clk, reset (async high), scan_enable, scan_in, A, B, opcode
//        -> result, zero_flag, scan_out (chain MSB, a_q[3]).
// Macro SCAN_ALU_RESULT_REG_EN: register result/zero_flag (one-cycle latency).
module scan_chain_alu
  import scan_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_enable,
  input  logic              scan_in,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              scan_out
);

  logic [CHAIN_LEN-1:0] chain;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_zero;

  assign a_q = chain[CHAIN_LEN-1:DATA_W];
  assign b_q = chain[DATA_W-1:0];

  // Chain MSB leaves first, so the old MSB is visible before each shift.
  assign scan_out = chain[CHAIN_LEN-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      chain <= '0;
    else if (scan_enable)
      chain <= {chain[CHAIN_LEN-2:0], scan_in};
    else
      chain <= {A, B};
  end

  alu4_comb u_alu (
    .a      (a_q),
    .b      (b_q),
    .opcode (opcode),
    .result (alu_res),
    .zero   (alu_zero)
  );

`ifdef SCAN_ALU_RESULT_REG_EN
  // Output register runs in both modes and sits outside the scan chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      zero_flag <= 1'b1;
    end else begin
      result    <= alu_res;
      zero_flag <= alu_zero;
    end
  end
`else
  assign result    = alu_res;
  assign zero_flag = alu_zero;
`endif

endmodule

// File: tb/tb_scan_chain_alu.sv
// Self-checking bench for scan_chain_alu: vector table, scan sequences,
// async reset corner and randomized run against a behavioural model.
module tb_scan_chain_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_enable;
  logic       scan_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opcode;
  logic [3:0] result;
  logic       zero_flag;
  logic       scan_out;

  int passed = 0;
  int total  = 0;

  // Model: chain as an integer 0..255 (A in the high nibble),
  // plus the modelled output register for the registered build.
  int m_chain = 0;
  int m_res   = 0;

  typedef struct {
    int a;
    int b;
    int op;
    int res;
    int zero;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  scan_chain_alu dut (
    .clk         (clk),
    .reset       (reset),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .A           (A),
    .B           (B),
    .opcode      (opcode),
    .result      (result),
    .zero_flag   (zero_flag),
    .scan_out    (scan_out)
  );

  function automatic int ref_alu(int a, int b, int op);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return 15 - a;
      6:       return (a * 2) % 16;
      default: return a / 2;
    endcase
  endfunction

  function int exp_res();
`ifdef SCAN_ALU_RESULT_REG_EN
    return m_res;
`else
    return ref_alu(m_chain / 16, m_chain % 16, int'(opcode));
`endif
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_outs(input string name);
    int e;
    e = exp_res();
    check({name, " result"}, int'(result), e);
    check({name, " zero_flag"}, int'(zero_flag), (e == 0) ? 1 : 0);
    check({name, " scan_out"}, int'(scan_out), m_chain / 128);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_res = ref_alu(m_chain / 16, m_chain % 16, int'(opcode));
      if (scan_enable) m_chain = (m_chain * 2 + int'(scan_in)) % 256;
      else m_chain = int'(A) * 16 + int'(B);
    end
    #1;
  endtask

  initial begin
    int sbits[8];
    int obits[8];
    tbl[0]  = '{3, 1, 0, 4, 0};
    tbl[1]  = '{3, 1, 1, 2, 0};
    tbl[2]  = '{5, 5, 1, 0, 1};
    tbl[3]  = '{15, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 1, 15, 0};
    tbl[5]  = '{8, 0, 6, 0, 1};
    tbl[6]  = '{15, 0, 5, 0, 1};
    tbl[7]  = '{9, 6, 2, 0, 1};
    tbl[8]  = '{9, 6, 3, 15, 0};
    tbl[9]  = '{9, 6, 4, 15, 0};
    tbl[10] = '{9, 3, 7, 4, 0};
    tbl[11] = '{12, 10, 2, 8, 0};
    sbits = '{1, 0, 1, 0, 0, 1, 0, 1};
    obits = '{1, 1, 0, 0, 0, 0, 1, 1};

    reset = 1'b1;
    scan_enable = 1'b1;
    scan_in = 1'b1;
    A = 4'hF;
    B = 4'hF;
    opcode = 3'b000;
    #1;
    check_outs("reset");
    check("reset result const", int'(result), 0);
    check("reset zero const", int'(zero_flag), 1);
    repeat (3) tick();
    check_outs("reset held with shift");
    opcode = 3'b101;
    #1;
    check_outs("reset held NOT");
    opcode = 3'b000;
    @(negedge clk);
    reset = 1'b0;

    scan_enable = 1'b0;
    foreach (tbl[i]) begin
      A = 4'(tbl[i].a);
      B = 4'(tbl[i].b);
      opcode = 3'(tbl[i].op);
      tick();
      check_outs($sformatf("vec%0d first", i));
      tick();
      check($sformatf("vec%0d result", i), int'(result), tbl[i].res);
      check($sformatf("vec%0d zero", i), int'(zero_flag), tbl[i].zero);
    end

    scan_enable = 1'b1;
    opcode = 3'b000;
    A = 4'h0;
    B = 4'h0;
    for (int i = 0; i < 8; i++) begin
      scan_in = sbits[i][0];
      tick();
    end
    check("scan load msb", int'(scan_out), 1);
    check_outs("scan load");
`ifndef SCAN_ALU_RESULT_REG_EN
    opcode = 3'b001;
    #1;
    check("scan load SUB", int'(result), 5);
    opcode = 3'b011;
    #1;
    check("scan load OR", int'(result), 15);
    check("scan load OR zero", int'(zero_flag), 0);
`endif

    scan_enable = 1'b0;
    A = 4'hC;
    B = 4'h3;
    opcode = 3'b000;
    tick();
    scan_enable = 1'b1;
    scan_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan out bit%0d", i), int'(scan_out), obits[i]);
      tick();
    end
    check_outs("scan out drained");
`ifndef SCAN_ALU_RESULT_REG_EN
    check("drained result", int'(result), 0);
`endif

    scan_enable = 1'b0;
    A = 4'hF;
    B = 4'hF;
    tick();
    scan_enable = 1'b1;
    scan_in = 1'b1;
    repeat (3) tick();
    check_outs("pre reset shift");
    #2;
    reset = 1'b1;
    #1;
    m_chain = 0;
    m_res = 0;
    check_outs("async reset mid shift");
    check("async reset scan_out", int'(scan_out), 0);
    check("async reset zero", int'(zero_flag), 1);
    reset = 1'b0;

`ifdef SCAN_ALU_RESULT_REG_EN
    scan_enable = 1'b0;
    A = 4'h3;
    B = 4'h1;
    opcode = 3'b000;
    tick();
    check("latency first edge", int'(result), 0);
    tick();
    check("latency second edge", int'(result), 4);
`endif

    for (int i = 0; i < 300; i++) begin
      scan_enable = 1'($urandom % 2);
      scan_in = 1'($urandom % 2);
      A = 4'($urandom % 16);
      B = 4'($urandom % 16);
      opcode = 3'($urandom % 8);
      tick();
      check_outs($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
